// File: rtl/i2s_pkg.sv
// Shared types and default sizes for the I2S receive path.
package i2s_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 6;
    localparam int ERR_W_DEF = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with a history flop
// for rising/falling edge detection in the clk domain.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Synchroniser chain plus one history stage
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            hist_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~hist_r;
    assign fall = ~sync_r & hist_r;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdata in the clk domain, assembles
// MSB-first left-justified words and emits one stereo pair per frame.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i2s_bclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_sdata,
    input  logic             enable,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_l,
    output logic [WIDTH-1:0] out_r,
    output logic             out_valid,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   WIDTH_C = (CNT_W+1)'(WIDTH);

    logic bclk_sync_s, bclk_rise_s, bclk_fall_s;
    logic lrclk_sync_s, lrclk_rise_s, lrclk_fall_s;
    logic sdata_sync_s, sdata_rise_s, sdata_fall_s;
    logic unused_s;

    i2s_state_e       state_r, state_next_s;
    logic             lr_prev_r;
    logic [WIDTH-1:0] word_r;
    logic [CNT_W-1:0] bitcnt_r;
    logic [WIDTH-1:0] l_hold_r;
    logic [WIDTH-1:0] out_l_r, out_r_r;
    logic             out_valid_r, frame_err_r, locked_r;
    logic [ERR_W-1:0] err_count_r;

    logic             boundary_s;
    logic [WIDTH-1:0] bit_mask_s;
    logic [WIDTH-1:0] word_close_s;
    logic [CNT_W:0]   close_len_s;
    logic [CNT_W-1:0] bitcnt_inc_s;
    logic             zero_s, short_s, latch_l_s, emit_s;

    sync_edge u_bclk (
        .clk      (clk),
        .reset    (reset),
        .async_in (i2s_bclk),
        .sync     (bclk_sync_s),
        .rise     (bclk_rise_s),
        .fall     (bclk_fall_s)
    );

    sync_edge u_lrclk (
        .clk      (clk),
        .reset    (reset),
        .async_in (i2s_lrclk),
        .sync     (lrclk_sync_s),
        .rise     (lrclk_rise_s),
        .fall     (lrclk_fall_s)
    );

    sync_edge u_sdata (
        .clk      (clk),
        .reset    (reset),
        .async_in (i2s_sdata),
        .sync     (sdata_sync_s),
        .rise     (sdata_rise_s),
        .fall     (sdata_fall_s)
    );

    assign unused_s = ^{bclk_sync_s, bclk_fall_s, lrclk_rise_s, lrclk_fall_s,
                        sdata_rise_s, sdata_fall_s};

    // Bit placement: bit n of a word lands at WIDTH-1-n; bits past WIDTH shift out
    always_comb begin
        boundary_s = bclk_rise_s & (lrclk_sync_s ^ lr_prev_r);
        bit_mask_s = MSB_ONE >> bitcnt_r;
        if (sdata_sync_s) begin
            word_close_s = word_r | bit_mask_s;
        end else begin
            word_close_s = word_r;
        end
        close_len_s = {1'b0, bitcnt_r} + {1'b0, CNT_ONE};
        if (bitcnt_r == CNT_MAX) begin
            bitcnt_inc_s = CNT_MAX;
        end else begin
            bitcnt_inc_s = bitcnt_r + CNT_ONE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SYNC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a word holding only the boundary bit forces resync
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            SYNC: begin
                if (enable && boundary_s && !lrclk_sync_s) begin
                    state_next_s = LEFT;
                end else begin
                    state_next_s = SYNC;
                end
            end
            LEFT: begin
                if (!enable) begin
                    state_next_s = SYNC;
                end else if (boundary_s) begin
                    state_next_s = (bitcnt_r == CNT_ZERO) ? SYNC : RIGHT;
                end else begin
                    state_next_s = LEFT;
                end
            end
            RIGHT: begin
                if (!enable) begin
                    state_next_s = SYNC;
                end else if (boundary_s) begin
                    state_next_s = (bitcnt_r == CNT_ZERO) ? SYNC : LEFT;
                end else begin
                    state_next_s = RIGHT;
                end
            end
            default: state_next_s = SYNC;
        endcase
    end

    // FSM outputs: word-close events decoded from the current state
    always_comb begin
        zero_s    = 1'b0;
        short_s   = 1'b0;
        latch_l_s = 1'b0;
        emit_s    = 1'b0;
        if (enable && boundary_s && (state_r != SYNC)) begin
            zero_s    = (bitcnt_r == CNT_ZERO);
            short_s   = (close_len_s < WIDTH_C);
            latch_l_s = (state_r == LEFT) && (bitcnt_r != CNT_ZERO);
            emit_s    = (state_r == RIGHT) && (bitcnt_r != CNT_ZERO);
        end else begin
            zero_s    = 1'b0;
            short_s   = 1'b0;
            latch_l_s = 1'b0;
            emit_s    = 1'b0;
        end
    end

    // lrclk history tracks every bclk edge, even while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev_r <= 1'b0;
        end else if (bclk_rise_s) begin
            lr_prev_r <= lrclk_sync_s;
        end else begin
            lr_prev_r <= lr_prev_r;
        end
    end

    // Word assembly; cleared at every boundary, while disabled and in SYNC
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r   <= {WIDTH{1'b0}};
            bitcnt_r <= CNT_ZERO;
        end else if (!enable || (state_r == SYNC) || boundary_s) begin
            word_r   <= {WIDTH{1'b0}};
            bitcnt_r <= CNT_ZERO;
        end else if (bclk_rise_s) begin
            word_r   <= word_close_s;
            bitcnt_r <= bitcnt_inc_s;
        end else begin
            word_r   <= word_r;
            bitcnt_r <= bitcnt_r;
        end
    end

    // Sample hold and output strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            l_hold_r    <= {WIDTH{1'b0}};
            out_l_r     <= {WIDTH{1'b0}};
            out_r_r     <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            out_valid_r <= emit_s;
            frame_err_r <= short_s | zero_s;
            locked_r    <= (state_next_s != SYNC);
            if (latch_l_s) begin
                l_hold_r <= word_close_s;
            end else begin
                l_hold_r <= l_hold_r;
            end
            if (emit_s) begin
                out_l_r <= l_hold_r;
                out_r_r <= word_close_s;
            end else begin
                out_l_r <= out_l_r;
                out_r_r <= out_r_r;
            end
        end
    end

    // Saturating error counter; clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_r <= {ERR_W{1'b0}};
        end else if (err_clr) begin
            err_count_r <= {ERR_W{1'b0}};
        end else if (frame_err_r && (err_count_r != ERR_MAX)) begin
            err_count_r <= err_count_r + ERR_ONE;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign out_l     = out_l_r;
    assign out_r     = out_r_r;
    assign out_valid = out_valid_r;
    assign frame_err = frame_err_r;
    assign err_count = err_count_r;
    assign locked    = locked_r;

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Upstream audio-ingest stage for the stereo MPX encoder: deserialises an external I2S stream (bclk, lrclk, sdata) into parallel signed left/right samples.
- Presents one L/R pair per stereo frame as out_l/out_r with a single-cycle out_valid strobe; these drive the encoder's in_l/in_r/in_valid.
- All I2S pins are asynchronous to clk. They are synchronised and oversampled in the clk domain; clk must be at least 4x bclk.
- Detects short and malformed frames and counts them for software.

Parameters:
- WIDTH, 16, output sample width in bits; words are MSB-first and left-justified.
- CNT_W, 6, width of the per-channel bit counter; the counter saturates at 2^CNT_W-1.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i2s_bclk  in  1  I2S bit clock (asynchronous).
- i2s_lrclk  in  1  I2S word select; 0 = left, 1 = right (asynchronous).
- i2s_sdata  in  1  I2S serial data (asynchronous).
- enable  in  1  receive enable; level-sensitive.
- err_clr  in  1  single-cycle pulse; clears err_count.
- out_l  out  WIDTH  left sample (signed).
- out_r  out  WIDTH  right sample (signed).
- out_valid  out  1  single-cycle strobe marking a new out_l/out_r pair.
- frame_err  out  1  single-cycle strobe marking a malformed channel word.
- err_count  out  ERR_W  saturating count of frame_err strobes.
- locked  out  1  high while the state machine is in LEFT or RIGHT.

Behaviour:
- Reset values: out_l=0, out_r=0, out_valid=0, frame_err=0, err_count=0, locked=0, state=SYNC. Shift register, bit counter and synchroniser flops are all cleared.
- Input conditioning:
  - Each pin passes through a 2-flop synchroniser plus one history flop.
  - bclk_rise = sync=1 and hist=0.
  - lrclk and sdata are sampled only in bclk_rise cycles, on their synchronised values, so all three pins see equal delay.
- Bit attribution (I2S one-bit delay): each sampled bit belongs to the channel given by lrclk as sampled at the previous bclk_rise (lr_prev).
  - A word boundary occurs at a bclk_rise where the current lrclk differs from lr_prev.
  - The bit sampled at that edge is the final (LSB-side) bit of the closing word.
- Word assembly:
  - The first WIDTH bits of a word are shifted in MSB-first; later bits are ignored.
  - bitcnt increments per bit, saturating at 2^CNT_W-1.
  - On close with bitcnt < WIDTH, the word is left-justified with zero padding in the LSBs and frame_err pulses.
  - bitcnt and the shift register reset at every word boundary.
- State machine, SYNC -> LEFT -> RIGHT -> LEFT ...:
  - SYNC: discard all bits. On a boundary where lrclk goes 1->0, enter LEFT. No output and no error in SYNC.
  - LEFT: on a boundary (0->1), latch the assembled word into an internal l_hold register and enter RIGHT.
  - RIGHT: on a boundary (1->0), load out_l<=l_hold and out_r<=assembled word, pulse out_valid, and enter LEFT.
- Timing: out_valid and frame_err assert in the clk cycle immediately after the bclk_rise cycle that closes the word (1-cycle registered latency). out_l/out_r hold their values between strobes.
- Zero-length word: a boundary with bitcnt=0 (lrclk glitch) pulses frame_err and returns to SYNC. No out_valid.
- enable=0:
  - Next cycle: state=SYNC, locked=0, and the partial word is discarded.
  - out_l/out_r keep their last values; err_count is kept.
  - On re-enable, the first emitted pair is the first complete L+R frame after a 1->0 lrclk edge.
- err_count:
  - Increments on each frame_err and saturates at 2^ERR_W-1.
  - err_clr has priority over a simultaneous increment; the result is 0.
- Reset mid-frame: everything returns to reset values the next cycle, and resync is required.

Decomposition:
- Package i2s_pkg: state enum (SYNC, LEFT, RIGHT), with CNT_W and ERR_W defaults as localparams.
- Sub-module sync_edge: 2-flop synchroniser plus history flop, outputs sync, rise and fall. Instantiate three times, once each for bclk, lrclk and sdata.

Test Plan:
- Nominal: clk = 8x bclk, 32 bclk per channel, L=0x1234, R=0xABCD for 3 frames -> from the second frame, out_valid pulses once per frame with out_l=0x1234, out_r=0xABCD; frame_err never pulses.
- Exact width: 16 bclk per channel, L=0x8001, R=0x7FFE -> out_l=0x8001, out_r=0x7FFE; no error.
- Short word: right channel has only 12 bits, 0xABC -> out_r=0xABC0, frame_err pulses once, err_count=1; the next normal frame decodes correctly.
- Glitch: 1-bclk lrclk pulse mid-left-word -> frame_err, locked=0; no out_valid until the next full frame after a 1->0 lrclk edge.
- enable dropped mid-RIGHT for 10 bclk, then raised -> no out_valid for the broken frame; the first pair is the next complete frame; err_count unchanged.
- Counter: force 2^16+5 errors -> err_count=0xFFFF. err_clr together with a frame_err -> err_count=0. Reset mid-frame -> all outputs 0, locked=0.
